barrier_sequencer: RTL and testbench
====================================

// Module: barrier_sequencer
// PURPOSE
//  Synthesizable, clocked barrier controller for the NetFPGA-1G testbench and hardware self-test.
//  Collects barrier-ready flags from NUM_PORTS interface agents and one PCI agent.
//  Issues a single registered barrier_proceed once every requester is ready.
//  Counts completed barriers and flags a stuck barrier after a programmable idle timeout.
//  Reports which requesters were missing when the timeout fired.
// PARAMETERS
//  NUM_PORTS       4      number of interface requesters
//  TIMEOUT_CYCLES  25000  idle clk cycles allowed in GATHER before error (200 us at 125 MHz); must be >= 2
//  CNT_WIDTH       16     width of timeout counter; 2**CNT_WIDTH > TIMEOUT_CYCLES
//  EPOCH_WIDTH     8      width of completed-barrier counter
// PORTS
//  clk              in   1              system clock
//  reset            in   1              asynchronous reset, active-high
//  if_good          in   NUM_PORTS      per-interface barrier-ready flags
//  pci_good         in   1              PCI barrier-ready flag
//  if_activity      in   NUM_PORTS      per-interface traffic-activity flags
//  pci_activity     in   1              PCI traffic-activity flag
//  clear_err        in   1              one-cycle pulse; leaves ERROR state
//  barrier_proceed  out  1              all requesters ready; release barrier
//  barrier_epoch    out  EPOCH_WIDTH    number of completed barriers, wraps
//  timeout_err      out  1              high while in ERROR
//  missing_mask     out  NUM_PORTS+1    requesters not ready at timeout; bit0=pci, bit i+1=if_good[i]
// BEHAVIOUR
//  - Clock and reset
//    - All inputs are synchronous to clk.
//    - On reset: state=IDLE, cnt=0, barrier_proceed=0, barrier_epoch=0, timeout_err=0, missing_mask=0.
//    - Reset mid-barrier aborts the barrier with no pulse and no epoch change.
//  - Signal definitions
//    - req = {if_good, pci_good}; ALL = (req all ones); NONE = (req == 0).
//    - act = |{if_activity, pci_activity}.
//  - All outputs are registered and update on the edge that moves the FSM.
//  - FSM states: IDLE, GATHER, PROCEED, ERROR.
//  - IDLE
//    - ALL -> PROCEED; barrier_proceed=1 after that edge.
//    - Otherwise !NONE -> GATHER with cnt=0.
//  - GATHER (evaluate in this priority order)
//    1. ALL -> PROCEED; barrier_proceed=1 on the next edge. Latency is 1 clk from the last flag rising.
//    2. NONE -> IDLE (aborted); epoch unchanged.
//    3. act -> cnt=0. Activity restarts the idle window.
//    4. cnt == TIMEOUT_CYCLES-1 -> ERROR; missing_mask=~req, timeout_err=1.
//    5. Otherwise cnt=cnt+1.
//    - ALL and timeout in the same cycle: ALL wins.
//  - PROCEED
//    - barrier_proceed stays 1 while !NONE. Flags may drop one at a time.
//    - NONE -> IDLE; barrier_proceed=0 and barrier_epoch=barrier_epoch+1 on the same edge.
//    - barrier_epoch wraps from all-ones to 0.
//    - No timeout counting in PROCEED.
//  - ERROR
//    - Sticky: timeout_err=1 and missing_mask held; req is ignored.
//    - clear_err -> IDLE; timeout_err=0, missing_mask=0, cnt=0.
//    - clear_err outside ERROR has no effect.
//  - barrier_proceed is never 1 while timeout_err is 1.
// TESTING (NUM_PORTS=4, TIMEOUT_CYCLES=8)
//  1. Raise the flags in order pci, if0..if3, one per clk -> proceed=1 exactly 1 clk after if3 rises.
//     Drop all flags -> proceed=0, epoch 0->1.
//  2. req=5'b11110 held, no activity -> timeout_err=1 after 8 clks in GATHER, missing_mask=5'b00001.
//     clear_err -> IDLE, err=0, mask=0.
//  3. req=5'b00011 with activity pulsed every 5 clks for 40 clks -> no timeout.
//     Then complete req -> proceed=1.
//  4. Flags rise, then all drop before completion -> back to IDLE, no proceed, epoch unchanged.
//  5. Last flag rises on the cycle cnt=7 -> PROCEED, not ERROR.
//  6. Run 256 barriers -> epoch wraps to 0.
//     Assert reset while proceed=1 -> all outputs 0 immediately (asynchronous).

Source files
------------

// File: rtl/barrier_sequencer.sv
// Barrier controller: gathers ready flags from NUM_PORTS interfaces plus PCI,
// releases one registered proceed, counts epochs and flags stuck barriers.
module barrier_sequencer #(
   parameter int NUM_PORTS      = 4,
   parameter int TIMEOUT_CYCLES = 25000,
   parameter int CNT_WIDTH      = 16,
   parameter int EPOCH_WIDTH    = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_PORTS-1:0]   if_good,
   input  logic                   pci_good,
   input  logic [NUM_PORTS-1:0]   if_activity,
   input  logic                   pci_activity,
   input  logic                   clear_err,
   output logic                   barrier_proceed,
   output logic [EPOCH_WIDTH-1:0] barrier_epoch,
   output logic                   timeout_err,
   output logic [NUM_PORTS:0]     missing_mask
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GATHER  = 2'd1,
      PROCEED = 2'd2,
      ERROR   = 2'd3
   } state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

   state_t               state;
   logic [CNT_WIDTH-1:0] cnt;
   logic [NUM_PORTS:0]   req;
   logic                 req_all;
   logic                 req_none;
   logic                 act;

   assign req      = {if_good, pci_good};
   assign req_all  = &req;
   assign req_none = ~|req;
   assign act      = |{if_activity, pci_activity};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state           <= IDLE;
         cnt             <= '0;
         barrier_proceed <= 1'b0;
         barrier_epoch   <= '0;
         timeout_err     <= 1'b0;
         missing_mask    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_all) begin
                  state           <= PROCEED;
                  barrier_proceed <= 1'b1;
               end else if (!req_none) begin
                  state <= GATHER;
                  cnt   <= '0;
               end
            end
            GATHER: begin
               // Completion outranks the timeout when both land on the same edge.
               if (req_all) begin
                  state           <= PROCEED;
                  barrier_proceed <= 1'b1;
               end else if (req_none) begin
                  state <= IDLE;
               end else if (act) begin
                  cnt <= '0;
               end else if (cnt == CNT_LAST) begin
                  state        <= ERROR;
                  timeout_err  <= 1'b1;
                  missing_mask <= ~req;
               end else begin
                  cnt <= cnt + CNT_WIDTH'(1);
               end
            end
            PROCEED: begin
               if (req_none) begin
                  state           <= IDLE;
                  barrier_proceed <= 1'b0;
                  barrier_epoch   <= barrier_epoch + EPOCH_WIDTH'(1);
               end
            end
            ERROR: begin
               if (clear_err) begin
                  state        <= IDLE;
                  timeout_err  <= 1'b0;
                  missing_mask <= '0;
                  cnt          <= '0;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_barrier_sequencer.sv
// Directed self-checking bench for barrier_sequencer with a short timeout.
module tb_barrier_sequencer;

   localparam int NP = 4;

   logic          clk;
   logic          reset;
   logic [NP-1:0] if_good;
   logic          pci_good;
   logic [NP-1:0] if_activity;
   logic          pci_activity;
   logic          clear_err;
   logic          barrier_proceed;
   logic [7:0]    barrier_epoch;
   logic          timeout_err;
   logic [NP:0]   missing_mask;

   int errors = 0;
   int checks = 0;

   barrier_sequencer #(
      .NUM_PORTS(NP),
      .TIMEOUT_CYCLES(8),
      .CNT_WIDTH(4),
      .EPOCH_WIDTH(8)
   ) dut (
      .clk(clk),
      .reset(reset),
      .if_good(if_good),
      .pci_good(pci_good),
      .if_activity(if_activity),
      .pci_activity(pci_activity),
      .clear_err(clear_err),
      .barrier_proceed(barrier_proceed),
      .barrier_epoch(barrier_epoch),
      .timeout_err(timeout_err),
      .missing_mask(missing_mask)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input logic [4:0] r);
      pci_good = r[0];
      if_good  = r[4:1];
   endtask

   initial begin
      reset        = 1'b1;
      if_good      = '0;
      pci_good     = 1'b0;
      if_activity  = '0;
      pci_activity = 1'b0;
      clear_err    = 1'b0;
      tick();
      tick();
      check("rst_proceed", 32'(barrier_proceed), 32'd0);
      check("rst_epoch", 32'(barrier_epoch), 32'd0);
      check("rst_err", 32'(timeout_err), 32'd0);
      check("rst_mask", 32'(missing_mask), 32'd0);
      reset = 1'b0;
      tick();

      // 1: flags rise one per clock, pci first
      set_req(5'b00001); tick();
      set_req(5'b00011); tick();
      set_req(5'b00111); tick();
      set_req(5'b01111); tick();
      check("t1_pre_proceed", 32'(barrier_proceed), 32'd0);
      set_req(5'b11111); tick();
      check("t1_proceed", 32'(barrier_proceed), 32'd1);
      set_req(5'b10111); tick();
      check("t1_hold", 32'(barrier_proceed), 32'd1);
      set_req(5'b00000); tick();
      check("t1_drop", 32'(barrier_proceed), 32'd0);
      check("t1_epoch", 32'(barrier_epoch), 32'd1);

      // 2: pci missing, no activity -> timeout after 8 clocks in GATHER
      set_req(5'b11110); tick();
      for (int i = 0; i < 7; i++) tick();
      check("t2_no_err_yet", 32'(timeout_err), 32'd0);
      tick();
      check("t2_err", 32'(timeout_err), 32'd1);
      check("t2_mask", 32'(missing_mask), 32'h01);
      set_req(5'b11111); tick(); tick();
      check("t2_sticky_err", 32'(timeout_err), 32'd1);
      check("t2_no_proceed", 32'(barrier_proceed), 32'd0);
      check("t2_sticky_mask", 32'(missing_mask), 32'h01);
      set_req(5'b00000);
      clear_err = 1'b1; tick();
      clear_err = 1'b0;
      check("t2_clr_err", 32'(timeout_err), 32'd0);
      check("t2_clr_mask", 32'(missing_mask), 32'd0);
      check("t2_epoch", 32'(barrier_epoch), 32'd1);

      // 3: activity every 5 clocks keeps the barrier alive
      set_req(5'b00011); tick();
      for (int i = 0; i < 40; i++) begin
         if_activity[2] = (i % 5 == 4);
         tick();
      end
      if_activity = '0;
      check("t3_no_timeout", 32'(timeout_err), 32'd0);
      set_req(5'b11111); tick();
      check("t3_proceed", 32'(barrier_proceed), 32'd1);
      set_req(5'b00000); tick();
      check("t3_epoch", 32'(barrier_epoch), 32'd2);

      // 4: abort before completion
      set_req(5'b00001); tick();
      set_req(5'b00011); tick();
      set_req(5'b00000); tick(); tick();
      check("t4_no_proceed", 32'(barrier_proceed), 32'd0);
      check("t4_epoch", 32'(barrier_epoch), 32'd2);
      check("t4_no_err", 32'(timeout_err), 32'd0);

      // 5: completion on the cycle the counter hits its last value
      set_req(5'b00001); tick();
      for (int i = 0; i < 7; i++) tick();
      check("t5_pre_err", 32'(timeout_err), 32'd0);
      set_req(5'b11111); tick();
      check("t5_proceed", 32'(barrier_proceed), 32'd1);
      check("t5_err", 32'(timeout_err), 32'd0);
      set_req(5'b00000); tick();
      check("t5_epoch", 32'(barrier_epoch), 32'd3);

      // 6: epoch wrap, then asynchronous reset while proceed is high
      for (int i = 0; i < 252; i++) begin
         set_req(5'b11111); tick();
         set_req(5'b00000); tick();
      end
      check("t6_epoch_max", 32'(barrier_epoch), 32'd255);
      set_req(5'b11111); tick();
      set_req(5'b00000); tick();
      check("t6_epoch_wrap", 32'(barrier_epoch), 32'd0);
      set_req(5'b11111); tick();
      check("t6_proceed", 32'(barrier_proceed), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      check("t6_arst_proceed", 32'(barrier_proceed), 32'd0);
      check("t6_arst_epoch", 32'(barrier_epoch), 32'd0);
      check("t6_arst_err", 32'(timeout_err), 32'd0);
      check("t6_arst_mask", 32'(missing_mask), 32'd0);
      tick();
      reset = 1'b0;
      set_req(5'b00000);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
